// File: rtl/fetch_ctrl_if.sv
// Bus between the fetch/control sequencer and the datapath / instruction memory.
interface fetch_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);

  // Sequencer inputs
  logic                en;
  logic [31:0]         imem_data;
  logic                Zero;

  // Instruction memory address and IR field slices
  logic [PC_WIDTH-1:0] imem_addr;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [15:0]         SEin;
  logic [5:0]          FuncCode;

  // Datapath control lines
  logic                Regsel;
  logic                ALUsel;
  logic [1:0]          ALUOp;
  logic                MemRead;
  logic                MemWrite;
  logic                MemToRegSel;
  logic                RegWrite;

  // Debug / status
  logic [2:0]          state;
  logic                illegal_op;

  // Sequencer side
  modport master (
    input  en, imem_data, Zero,
    output imem_addr, rs, rt, rd, SEin, FuncCode,
    output Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel, RegWrite,
    output state, illegal_op
  );

  // Datapath / memory side
  modport slave (
    output en, imem_data, Zero,
    input  imem_addr, rs, rt, rd, SEin, FuncCode,
    input  Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel, RegWrite,
    input  state, illegal_op
  );

endinterface

// File: rtl/fetch_ctrl_fsm.sv
// Multi-cycle fetch/decode/control sequencer: owns PC and IR, drives the
// datapath control lines as a Moore decode of (state, opcode).
// PC_WIDTH must be at least 28 so the jump target field fits.
module fetch_ctrl_fsm #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Jump keeps the top PC nibble and replaces the rest
  localparam logic [PC_WIDTH-1:0] J_KEEP_MASK = ~PC_WIDTH'(32'h0FFF_FFFF);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;

  logic [5:0]          opcode;
  logic                legal_op;
  logic [PC_WIDTH-1:0] j_target;
  logic [PC_WIDTH-1:0] br_off;

  logic                regsel_c;
  logic                alusel_c;
  logic [1:0]          aluop_c;
  logic                memread_c;
  logic                memwrite_c;
  logic                memtoreg_c;
  logic                regwrite_c;
  logic                illegal_c;

  // Opcode, jump target and word-scaled signed branch offset
  always_comb begin
    opcode   = ir_q[31:26];
    legal_op = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
    j_target = (pc_q & J_KEEP_MASK) | PC_WIDTH'({ir_q[25:0], 2'b00});
    br_off   = {{(PC_WIDTH-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  end

  // State, PC and IR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next state plus PC/IR updates; everything holds while en is low
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (bus.en) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + PC_WIDTH'(4);
          state_d = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ: state_d = S_EXEC;
            OP_J: begin
              pc_d    = j_target;
              state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_LW, OP_SW:      state_d = S_MEM;
            OP_RTYPE, OP_ADDI: state_d = S_WB;
            OP_BEQ: begin
              if (bus.Zero) pc_d = pc_q + br_off;
              state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM:   state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        S_WB:    state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Moore control decode; ALU operand selects stay put from EXEC through WB
  always_comb begin
    regsel_c   = 1'b0;
    alusel_c   = 1'b0;
    aluop_c    = 2'b00;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      S_DECODE: illegal_c = ~legal_op;
      S_EXEC: begin
        case (opcode)
          OP_RTYPE:            aluop_c  = 2'b10;
          OP_LW, OP_SW, OP_ADDI: alusel_c = 1'b1;
          OP_BEQ:              aluop_c  = 2'b01;
          default: ;
        endcase
      end
      S_MEM: begin
        alusel_c   = 1'b1;
        memread_c  = (opcode == OP_LW);
        memwrite_c = (opcode == OP_SW);
      end
      S_WB: begin
        regwrite_c = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            regsel_c = 1'b1;
            aluop_c  = 2'b10;
          end
          OP_ADDI: alusel_c = 1'b1;
          OP_LW: begin
            alusel_c   = 1'b1;
            memread_c  = 1'b1;
            memtoreg_c = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // A stall must never commit a write
    if (!bus.en) begin
      regwrite_c = 1'b0;
      memwrite_c = 1'b0;
    end
  end

  // Drive the bus: fields straight from IR, controls from the decode
  assign bus.imem_addr   = pc_q;
  assign bus.rs          = ir_q[25:21];
  assign bus.rt          = ir_q[20:16];
  assign bus.rd          = ir_q[15:11];
  assign bus.SEin        = ir_q[15:0];
  assign bus.FuncCode    = ir_q[5:0];
  assign bus.Regsel      = regsel_c;
  assign bus.ALUsel      = alusel_c;
  assign bus.ALUOp       = aluop_c;
  assign bus.MemRead     = memread_c;
  assign bus.MemWrite    = memwrite_c;
  assign bus.MemToRegSel = memtoreg_c;
  assign bus.RegWrite    = regwrite_c;
  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal_c;

endmodule

// File: tb/tb_fetch_ctrl_fsm.sv
// Bench for fetch_ctrl_fsm: directed program plus random instructions,
// checked against an instruction-level reference model.
module tb_fetch_ctrl_fsm;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_ADDI = 3, C_BEQ = 4, C_J = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst;

  fetch_ctrl_if #(.PC_WIDTH(32)) bus ();

  fetch_ctrl_fsm #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [31:0] instr);
    case (instr[31:26])
      6'h00:   return C_R;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h08:   return C_ADDI;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // Cycles spent after FETCH: j/illegal 1, beq 2, R/addi/sw 3, lw 4
  function automatic int n_after(input int c);
    case (c)
      C_J, C_ILL: return 1;
      C_BEQ:      return 2;
      C_LW:       return 4;
      default:    return 3;
    endcase
  endfunction

  // Phase k of an instruction -> architectural state number
  function automatic logic [2:0] exp_state(input int c, input int k);
    if (k <= 2) return 3'(k);
    if (k == 3) return (c == C_LW || c == C_SW) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  // {Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel, RegWrite, illegal_op}
  function automatic logic [8:0] exp_ctrl(input int c, input int k, input logic en);
    logic       regsel, alusel, memrd, memwr, m2r, rw, ill;
    logic [1:0] aluop;
    regsel = 0; alusel = 0; memrd = 0; memwr = 0; m2r = 0; rw = 0; ill = 0; aluop = 2'b00;
    case (exp_state(c, k))
      3'd1: ill = (c == C_ILL);
      3'd2: begin
        if (c == C_R) aluop = 2'b10;
        if (c == C_LW || c == C_SW || c == C_ADDI) alusel = 1;
        if (c == C_BEQ) aluop = 2'b01;
      end
      3'd3: begin
        alusel = 1;
        memrd  = (c == C_LW);
        memwr  = (c == C_SW);
      end
      3'd4: begin
        rw = 1;
        if (c == C_R) begin regsel = 1; aluop = 2'b10; end
        if (c == C_ADDI) alusel = 1;
        if (c == C_LW) begin alusel = 1; memrd = 1; m2r = 1; end
      end
      default: ;
    endcase
    if (!en) begin rw = 0; memwr = 0; end
    return {regsel, alusel, aluop, memrd, memwr, m2r, rw, ill};
  endfunction

  task automatic check_cycle(input int c, input int k, input logic en);
    chk("state", 64'(bus.state), 64'(exp_state(c, k)));
    chk("ctrl", 64'({bus.Regsel, bus.ALUsel, bus.ALUOp, bus.MemRead, bus.MemWrite,
                      bus.MemToRegSel, bus.RegWrite, bus.illegal_op}), 64'(exp_ctrl(c, k, en)));
    chk("fields", 64'({bus.rs, bus.rt, bus.rd, bus.SEin, bus.FuncCode}),
        64'({m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[15:0], m_ir[5:0]}));
    chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
  endtask

  // Run one instruction from FETCH; optional one-cycle stall at phase stall_k,
  // optional reset in the middle of phase abort_k.
  task automatic run_instr(input logic [31:0] instr, input logic zero_v,
                           input int stall_k, input int abort_k);
    int c, n, off;
    c = classify(instr);
    n = n_after(c);
    for (int k = 0; k <= n; k++) begin
      if (k == stall_k) begin
        bus.en        = 1'b0;
        bus.imem_data = $urandom;
        bus.Zero      = 1'($urandom_range(0, 1));
        #1;
        check_cycle(c, k, 1'b0);
        @(posedge clk); #1;
      end
      bus.en        = 1'b1;
      bus.imem_data = (k == 0) ? instr : $urandom;
      bus.Zero      = (c == C_BEQ && k == 2) ? zero_v : 1'($urandom_range(0, 1));
      #1;
      check_cycle(c, k, 1'b1);
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        m_pc = 32'h0;
        m_ir = 32'h0;
        check_cycle(c, 0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        m_ir = instr;
        m_pc = m_pc + 32'd4;
      end else if (c == C_J && k == 1) begin
        m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
      end else if (c == C_BEQ && k == 2 && zero_v) begin
        off  = $signed(m_ir[15:0]);
        m_pc = m_pc + 32'(off * 4);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr(input int c);
    logic [5:0] op;
    case (c)
      C_R:     op = 6'h00;
      C_LW:    op = 6'h23;
      C_SW:    op = 6'h2B;
      C_ADDI:  op = 6'h08;
      C_BEQ:   op = 6'h04;
      C_J:     op = 6'h02;
      default: begin
        op = 6'($urandom);
        while (classify({op, 26'h0}) != C_ILL) op = 6'($urandom);
      end
    endcase
    return {op, 26'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n, sk, ak;
    logic [31:0] instr;

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.imem_data = 32'h0;
    bus.Zero      = 1'b0;
    m_pc          = 32'h0;
    m_ir          = 32'h0;
    #1;
    check_cycle(C_R, 0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed program
    run_instr(32'h0022_1820, 1'b0, -1, -1);
    chk("add_next_pc", 64'(bus.imem_addr), 64'h4);
    run_instr(32'h8C05_0008, 1'b0, -1, -1);
    run_instr(32'hAC05_000C, 1'b0, -1, -1);
    run_instr(32'h0022_1820, 1'b0, -1, -1);
    chk("pc_before_beq", 64'(bus.imem_addr), 64'h10);
    run_instr(32'h1021_0002, 1'b1, -1, -1);
    chk("beq_taken_pc", 64'(bus.imem_addr), 64'h1C);
    run_instr(32'h0800_0004, 1'b0, -1, -1);
    run_instr(32'h1021_0002, 1'b0, -1, -1);
    chk("beq_not_taken_pc", 64'(bus.imem_addr), 64'h14);
    run_instr(32'h0800_0004, 1'b0, -1, -1);
    run_instr(32'h1021_FFFF, 1'b1, -1, -1);
    chk("beq_negative_pc", 64'(bus.imem_addr), 64'h10);
    run_instr(32'h0800_0008, 1'b0, -1, -1);
    run_instr(32'h0800_0010, 1'b0, -1, -1);
    chk("j_target_pc", 64'(bus.imem_addr), 64'h40);
    run_instr(32'hFC00_0000, 1'b0, -1, -1);
    chk("illegal_next_pc", 64'(bus.imem_addr), 64'h44);

    // Stall during lw WB and sw MEM, then reset during sw MEM
    run_instr(32'h8C05_0008, 1'b0, 4, -1);
    run_instr(32'hAC05_000C, 1'b0, 3, -1);
    run_instr(32'hAC05_000C, 1'b0, -1, 3);
    chk("pc_after_abort", 64'(bus.imem_addr), 64'h0);

    // PC wrap-around both ways
    run_instr(32'h1000_FFFE, 1'b1, -1, -1);
    chk("pc_wrap_back", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    run_instr(32'h0022_1820, 1'b0, -1, -1);
    chk("pc_wrap_fwd", 64'(bus.imem_addr), 64'h0);

    // Random instruction stream with random stalls and rare aborts
    for (int i = 0; i < 250; i++) begin
      c     = int'($urandom_range(0, 6));
      instr = rand_instr(c);
      n     = n_after(c);
      sk    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
      ak    = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, n)) : -1;
      run_instr(instr, 1'($urandom_range(0, 1)), sk, ak);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_fsm.md
Name: fetch_ctrl_fsm

Overview:
Multi-cycle fetch/decode/control sequencer that sits directly upstream of the register-file/ALU/data-memory datapath. It holds the PC and the instruction register (IR) and reads instructions from an external instruction memory. It slices the IR into the rs/rt/rd/SEin/FuncCode fields and drives the datapath control lines (Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel, RegWrite) one state at a time. It uses the datapath Zero flag to resolve branches.

Parameters:
PC_WIDTH, 32, width of PC and imem_addr
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  advance enable; 0 = stall
imem_data  in  32  instruction word at imem_addr (combinational read)
Zero  in  1  ALU zero flag from datapath
imem_addr  out  PC_WIDTH  current PC
rs  out  5  IR[25:21]
rt  out  5  IR[20:16]
rd  out  5  IR[15:11]
SEin  out  16  IR[15:0]
FuncCode  out  6  IR[5:0]
Regsel  out  1  1 = write reg is rd, 0 = rt
ALUsel  out  1  1 = ALU B operand is sign-extended SEin
ALUOp  out  2  00 add, 01 subtract (beq), 10 use FuncCode
MemRead  out  1  data memory read
MemWrite  out  1  data memory write
MemToRegSel  out  1  1 = writeback from memory
RegWrite  out  1  register file write enable
state  out  3  FSM state (debug)
illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset (async, immediate): PC=RESET_PC, IR=0, state=FETCH, illegal_op=0. All control outputs are 0 while in FETCH.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Control outputs are a Moore decode of (state, IR opcode).
- FETCH: IR<=imem_data, PC<=PC+4, go to DECODE.
- DECODE: decode IR[31:26].
  - 000000 R-type, 100011 lw, 101011 sw, 001000 addi, 000100 beq: go to EXEC.
  - 000010 j: PC<={PC[31:28], IR[25:0], 2'b00}, go to FETCH.
  - Any other opcode: illegal_op=1 for this cycle, go to FETCH (treated as NOP).
- EXEC:
  - R-type: ALUOp=10, ALUsel=0, then WB.
  - lw/sw/addi: ALUOp=00, ALUsel=1; lw/sw go to MEM, addi goes to WB.
  - beq: ALUOp=01, ALUsel=0. If Zero=1, PC<=PC+(sign_extend(SEin)<<2), where PC already holds the fetched address+4. Then FETCH.
- MEM:
  - lw: ALUsel=1, MemRead=1, then WB.
  - sw: ALUsel=1, MemWrite=1, then FETCH.
- WB: RegWrite=1.
  - R-type: Regsel=1, MemToRegSel=0.
  - addi: Regsel=0, ALUsel=1, MemToRegSel=0.
  - lw: Regsel=0, ALUsel=1, MemRead=1, MemToRegSel=1.
  - Then FETCH.
- Cycle counts, FETCH to next FETCH: j 2, beq 3, R-type/addi/sw 4, lw 5.
- ALU operand controls are held stable from EXEC through WB for the same instruction.
- en=0: state, PC and IR hold; RegWrite and MemWrite are forced to 0; all other outputs hold.
- PC arithmetic is modulo 2^PC_WIDTH; wrap-around from max is legal.
- Branch offsets are signed; a negative offset moves the PC backward.
- Field outputs are always driven straight from IR, in every state.
- rst asserted mid-instruction aborts it: no write strobe may be asserted after rst rises.

Test Plan:
- Reset then en=1, imem_data=0x00221820 (add $3,$1,$2) -> imem_addr 0x0→0x4 after FETCH. rs=1, rt=2, rd=3, FuncCode=0x20. EXEC: ALUOp=10. WB: RegWrite=1, Regsel=1. Back to FETCH after 4 cycles.
- imem_data=0x8C050008 (lw $5,8($0)) -> EXEC: ALUsel=1, ALUOp=00. MEM: MemRead=1. WB: RegWrite=1, MemToRegSel=1, Regsel=0. 5 cycles total.
- imem_data=0xAC05000C (sw) -> MEM: MemWrite=1 for exactly one cycle, RegWrite never asserted. 4 cycles.
- beq 0x10210002 at PC 0x10 -> with Zero=1 next fetch is at 0x1C; repeat with Zero=0, next fetch is at 0x14. Also offset 0xFFFF with Zero=1 -> next fetch 0x10.
- j 0x08000010 at PC 0x20 -> next imem_addr=0x40 after 2 cycles. Opcode 0x3F (0xFC000000) -> illegal_op pulses once, no write strobes, next fetch at PC+4.
- Hold en=0 during an lw WB and assert rst during an sw MEM -> RegWrite/MemWrite drop immediately, state holds while stalled. Reset returns PC=0 and state=FETCH asynchronously.
